// File: rtl/z80_mmu_pkg.sv
// Shared types for the Z80 paging MMU: write-FSM states, control-register
// layout and a decoder for the control byte written by the CPU.
package z80_mmu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } mmu_state_e;

  typedef struct packed {
    logic wp_clr;
    logic en;
  } ctrl_t;

  localparam int CTRL_BIT_EN    = 0;
  localparam int CTRL_BIT_WPCLR = 1;

  // Extract the control fields from a byte written to the control port.
  function automatic ctrl_t decode_ctrl(input logic [7:0] d);
    ctrl_t c;
    c.en     = d[CTRL_BIT_EN];
    c.wp_clr = d[CTRL_BIT_WPCLR];
    return c;
  endfunction

endpackage

// File: rtl/z80_paged_mmu_if.sv
// Z80 core bus plus physical RAM strobes as seen by the paging MMU.
// The CPU/bench side uses the master modport, the MMU the slave modport.
// PHYS_AW must match the PHYS_AW of the z80_paged_mmu it connects to.
interface z80_paged_mmu_if #(
  parameter int PHYS_AW = 20
);
  logic [15:0]        cpu_addr;
  logic [7:0]         cpu_din;
  logic [7:0]         cpu_dout;
  logic               cpu_doe;
  logic               nMREQ;
  logic               nIORQ;
  logic               nRD;
  logic               nWR;
  logic               nM1;
  logic [PHYS_AW-1:0] ram_addr;
  logic               ram_ncs;
  logic               ram_noe;
  logic               ram_nwe;
  logic               wp_fault;

  modport master (
    output cpu_addr, cpu_din, nMREQ, nIORQ, nRD, nWR, nM1,
    input  cpu_dout, cpu_doe, ram_addr, ram_ncs, ram_noe, ram_nwe, wp_fault
  );

  modport slave (
    input  cpu_addr, cpu_din, nMREQ, nIORQ, nRD, nWR, nM1,
    output cpu_dout, cpu_doe, ram_addr, ram_ncs, ram_noe, ram_nwe, wp_fault
  );
endinterface

// File: rtl/z80_mmu_page_regs.sv
// Page register file: 2**IDX_W entries, one synchronous write port and two
// combinational read ports (address translation and CPU readback).
// Entries reset to their own index so the default map is the identity.
module z80_mmu_page_regs #(
  parameter int IDX_W   = 2,
  parameter int ENTRY_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr_a,
  output logic [ENTRY_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]   raddr_b,
  output logic [ENTRY_W-1:0] rdata_b
);
  localparam int NWIN = 1 << IDX_W;

  logic [ENTRY_W-1:0] mem [NWIN];

  // Register file update; reset restores the identity map.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset entry by entry because the identity map is
      // architecturally visible; it is small enough to live in flops.
      for (int i = 0; i < NWIN; i++) begin
        mem[i] <= ENTRY_W'(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/z80_paged_mmu.sv
// Paging MMU between a Z80 core bus and physical RAM. The 64 KB logical
// space is split into 2**WIN_BITS windows, each remapped through an
// I/O-programmed page register; a control port holds the global enable.
// Optional feature macro: MMU_WRITE_PROTECT_EN (per-page write protect
// bit on cpu_din[7] plus a sticky wp_fault flag).
// Parameter constraints: 16 < PHYS_AW <= 16-WIN_BITS+8; with write
// protect, PHYS_AW-(16-WIN_BITS) <= 7.
module z80_paged_mmu
  import z80_mmu_pkg::*;
#(
  parameter int         PHYS_AW  = 20,
  parameter int         WIN_BITS = 2,
  parameter logic [7:0] IO_BASE  = 8'h70
) (
  input logic            clk,
  input logic            reset,
  z80_paged_mmu_if.slave bus
);
  localparam int NWIN   = 1 << WIN_BITS;
  localparam int WIN_AW = 16 - WIN_BITS;
  localparam int PAGE_W = PHYS_AW - WIN_AW;
`ifdef MMU_WRITE_PROTECT_EN
  localparam int ENTRY_W = PAGE_W + 1;
`else
  localparam int ENTRY_W = PAGE_W;
`endif

  // ---------------------------------------------------------------- decode
  logic [WIN_BITS-1:0] win;
  logic [8:0]          io_off;
  logic                io_hit;
  logic                io_is_ctrl;
  logic [WIN_BITS-1:0] io_idx;
  logic                doe;

  assign win        = bus.cpu_addr[15:WIN_AW];
  // 9-bit offset: ports below IO_BASE wrap to >= 257 and never match.
  assign io_off     = {1'b0, bus.cpu_addr[7:0]} - {1'b0, IO_BASE};
  assign io_hit     = !bus.nIORQ && bus.nM1 && (io_off <= 9'(NWIN));
  assign io_is_ctrl = (io_off == 9'(NWIN));
  assign io_idx     = io_off[WIN_BITS-1:0];

  // ------------------------------------------------------------- write FSM
  mmu_state_e          state_q, state_d;
  logic                commit;
  logic [WIN_BITS-1:0] wr_idx_q;
  logic                wr_ctrl_q;
  logic [7:0]          wr_data_q;
  logic                en_q;
  ctrl_t               ctrl_wr;

  assign ctrl_wr = decode_ctrl(wr_data_q);

  // State register; target and data are captured when the I/O write starts
  // so the commit is immune to the bus moving on during COMMIT.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      wr_ctrl_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && io_hit && !bus.nWR) begin
        wr_idx_q  <= io_idx;
        wr_ctrl_q <= io_is_ctrl;
        wr_data_q <= bus.cpu_din;
      end
    end
  end

  // Next-state logic: one commit per I/O write, then wait for the cycle end.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:    if (io_hit && !bus.nWR) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = HOLD;
      end
      HOLD:    if (bus.nIORQ || bus.nWR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Global enable bit in the control register.
  always_ff @(posedge clk) begin
    if (reset)                   en_q <= 1'b0;
    else if (commit && wr_ctrl_q) en_q <= ctrl_wr.en;
  end

  // ------------------------------------------------------- page registers
  logic [ENTRY_W-1:0] page_wdata;
  logic [ENTRY_W-1:0] xl_entry;
  logic [ENTRY_W-1:0] rb_entry;
  logic [PAGE_W-1:0]  xl_page;
  logic [7:0]         rb_data;

  z80_mmu_page_regs #(
    .IDX_W   (WIN_BITS),
    .ENTRY_W (ENTRY_W)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .we      (commit && !wr_ctrl_q),
    .waddr   (wr_idx_q),
    .wdata   (page_wdata),
    .raddr_a (win),
    .rdata_a (xl_entry),
    .raddr_b (io_idx),
    .rdata_b (rb_entry)
  );

  assign xl_page = xl_entry[PAGE_W-1:0];

`ifdef MMU_WRITE_PROTECT_EN
  logic xl_wp;
  logic wp_hit;
  logic wp_fault_q;

  assign page_wdata = {wr_data_q[7], wr_data_q[PAGE_W-1:0]};
  assign rb_data    = {rb_entry[PAGE_W], 7'(rb_entry[PAGE_W-1:0])};
  assign xl_wp      = xl_entry[PAGE_W];
  assign wp_hit     = en_q && xl_wp && !bus.nMREQ && !bus.nWR;
  assign bus.ram_nwe = bus.nWR | bus.nMREQ | (en_q & xl_wp);

  // Sticky fault: a violation in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)                                       wp_fault_q <= 1'b0;
    else if (wp_hit)                                 wp_fault_q <= 1'b1;
    else if (commit && wr_ctrl_q && ctrl_wr.wp_clr)  wp_fault_q <= 1'b0;
  end

  assign bus.wp_fault = wp_fault_q;
`else
  assign page_wdata   = wr_data_q[PAGE_W-1:0];
  assign rb_data      = 8'(rb_entry);
  assign bus.ram_nwe  = bus.nWR | bus.nMREQ;
  assign bus.wp_fault = 1'b0;
`endif

  // Not every captured data bit is stored in every configuration.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data_q, ctrl_wr};

  // ------------------------------------------------------------ outputs
  assign bus.ram_addr = en_q ? {xl_page, bus.cpu_addr[WIN_AW-1:0]}
                             : PHYS_AW'(bus.cpu_addr);
  assign bus.ram_ncs  = bus.nMREQ;
  assign bus.ram_noe  = bus.nRD | bus.nMREQ;

  assign doe          = io_hit && !bus.nRD;
  assign bus.cpu_doe  = doe;
  assign bus.cpu_dout = !doe      ? 8'h00 :
                        io_is_ctrl ? {7'b0, en_q} : rb_data;

endmodule
